relu_act: RTL
=============

Name: relu_act

Overview:
- Activation stage directly downstream of add_bias; consumes its 12x32-lane biased vector.
- Per layer: applies ReLU with upper clip, or passes the vector through unchanged for the output layer.
- Processes one row of COLS lanes per clock, so 12 rows take 12 cycles.
- Holds the result on q and flags completion with a one-cycle valid pulse.

Parameters:
- DATA_LEN, 18: lane width; two's-complement fixed point, same format as add_bias output.
- ROWS, 12: number of rows per vector.
- COLS, 32: lanes per row, processed in parallel.
- MAX_VAL, 18'h1FFFF: positive clip ceiling for ReLU layers; the default means no clipping.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- load, input, 1: start request; rising-edge sensitive.
- cs, input, 3: layer select, sampled at start.
- d, input, ROWS*COLS*DATA_LEN: vector from add_bias.
- q, output, ROWS*COLS*DATA_LEN: activated vector.
- busy, output, 1: high while processing.
- valid, output, 1: one-cycle pulse when q is complete.

Behaviour:
- Lane indexing: lane i = r*COLS + c occupies d/q bits [i*DATA_LEN +: DATA_LEN]. Row 0 is the least-significant row.
- Reset, sampled at a clock edge with rst=1:
  - state=IDLE, q=0, busy=0, valid=0, row counter=0.
  - load_prev=1, so a load held high through reset does not start processing.
  - Reset mid-RUN aborts immediately; partial results are discarded (q=0).
- Start condition: state==IDLE && load==1 && load_prev==0 && cs in {1..5}.
  - cs of 0, 6 or 7 at the rising edge is ignored: no start and no later retrigger until load falls and rises again.
  - load_prev <= load on every non-reset edge.
- States are IDLE and RUN.
- Edge N (start):
  - Capture d into an internal register din and cs into mode.
  - row<=0, busy<=1, state<=RUN.
  - q is not modified.
- Edges N+1 .. N+ROWS (RUN): for row r=row, each lane x=din lane:
  - mode in {1..4}: y = 0 if x<0; y = MAX_VAL if x>MAX_VAL; otherwise y = x.
  - mode 5: y = x (bypass).
  - Write y into q row r; other rows of q are unchanged. Then row<=row+1.
- Completion at edge N+ROWS (row==ROWS-1):
  - state<=IDLE, busy<=0, valid<=1, row<=0.
- Edge N+ROWS+1: valid<=0. An accepted start may occur on this same edge if a fresh rising edge of load is present.
- Latency: valid is high in the cycle following edge N+12 (default ROWS). q is final and stable from that point until the next start plus 1 edge.
- Input handling:
  - load edges, cs changes and d changes during RUN are ignored; d and cs are used only as captured at start.
  - load_prev still tracks load during RUN, so a load that rises during RUN and stays high does not start a new pass at IDLE.
- busy and valid are never high in the same cycle.
- No arithmetic growth: output width equals input width. Comparisons are signed, and MAX_VAL is treated as signed positive.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with load=1 → q=0, busy=0, valid=0. Release rst with load held high → no start; busy stays 0 for 20 cycles.
- ReLU pass: d has all lanes of row r set to signed value (r-6)*4096; cs=1; pulse load.
  - busy=1 for exactly 12 cycles, then valid=1 for 1 cycle.
  - Rows 0-5 read 0; row 6 reads 0; rows 7-11 read (r-6)*4096.
- Bypass: same d, cs=5 → q equals d bit-exact, negatives preserved (row 0 lanes = 18'h3A000). valid appears 13 edges after the load edge.
- Clip: MAX_VAL=18'h04000; lanes set to 18'h1FFFF, 18'h04000, 18'h03FFF, 18'h20000; cs=2 → outputs 18'h04000, 18'h04000, 18'h03FFF, 18'h00000.
- Ignored inputs:
  - Load edge with cs=0 → no busy.
  - During RUN: change d to all 18'h00001, toggle load, set cs=5 → q reflects the originally captured d under mode 1; exactly one valid pulse.
  - Immediate new load edge at the valid cycle → second pass starts, valid 13 edges later.
- Reset mid-operation: assert rst at RUN row 5 → next edge q=0, busy=0, valid=0, and no valid pulse follows. A new load edge afterwards completes normally in 12 cycles.

Source files
------------

// File: rtl/relu_act.sv
// Activation stage after add_bias: per-row ReLU with upper clip, or bypass for the
// output layer. One row of COLS lanes is processed per clock; valid pulses once q is complete.
module relu_act #(
  parameter int                  DATA_LEN = 18,
  parameter int                  ROWS     = 12,
  parameter int                  COLS     = 32,
  parameter logic [DATA_LEN-1:0] MAX_VAL  = 18'h1FFFF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [2:0]                        cs,
  input  logic [ROWS*COLS*DATA_LEN-1:0]     d,
  output logic [ROWS*COLS*DATA_LEN-1:0]     q,
  output logic                              busy,
  output logic                              valid
);

  localparam int VW    = ROWS * COLS * DATA_LEN;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [VW-1:0]      din_q, din_d;
  logic [VW-1:0]      q_q, q_d;
  logic [2:0]         mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               load_prev_q, load_prev_d;
  logic               start_s;

  // Modes 1..4 clamp to [0, MAX_VAL] (signed); mode 5 passes the lane through.
  function automatic logic [DATA_LEN-1:0] activate(input logic [DATA_LEN-1:0] x,
                                                   input logic [2:0]          mode);
    logic [DATA_LEN-1:0] y;
    if (mode == 3'd5) begin
      y = x;
    end else if (x[DATA_LEN-1]) begin
      y = '0;
    end else if ($signed(x) > $signed(MAX_VAL)) begin
      y = MAX_VAL;
    end else begin
      y = x;
    end
    return y;
  endfunction

  assign start_s = load && !load_prev_q && (cs != 3'd0) && (cs <= 3'd5);

  // Next-state logic: capture at start, then write one activated row per cycle.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    din_d       = din_q;
    q_d         = q_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    load_prev_d = load;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          din_d   = d;
          mode_d  = cs;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int c = 0; c < COLS; c++) begin
          q_d[(int'(row_q) * COLS + c) * DATA_LEN +: DATA_LEN] =
            activate(din_q[(int'(row_q) * COLS + c) * DATA_LEN +: DATA_LEN], mode_q);
        end
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          row_d   = '0;
        end else begin
          row_d   = row_q + ROW_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; load_prev resets high so a load held through reset cannot start a pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      din_q       <= '0;
      q_q         <= '0;
      mode_q      <= 3'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      load_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      din_q       <= din_d;
      q_q         <= q_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      load_prev_q <= load_prev_d;
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule
